// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage of the pipelined RV32I core. This block owns the
// program counter and drives it out as the instruction-memory address. It
// captures the word that comes back into the IF/ID pipeline register. Stall
// requests from hazard detection freeze the stage. A redirect from EX (taken
// branch, JAL, JALR) reloads the PC and puts a NOP bubble into IF/ID. Three
// free-running counters keep fetch, bubble and stall statistics.
//
// Parameters
//   RESET_PC    PC loaded on reset (must be word-aligned)
//   NOP_INSTR   bubble word placed in IF/ID (addi x0,x0,0)
//
// Ports
//   clk          core clock, rising-edge
//   reset        synchronous, active-high
//   stall        hold PC and IF/ID
//   redirect     load redirect_pc and insert a bubble (wins over stall)
//   redirect_pc  redirect target; bits [1:0] are ignored
//   imem_addr    byte address to instruction memory (the PC register)
//   imem_rdata   instruction word read combinationally from imem_addr
//   ifid_pc      PC of the instruction held in IF/ID
//   ifid_pc4     ifid_pc + 4 (link value)
//   ifid_instr   instruction held in IF/ID
//   ifid_opcode  ifid_instr[6:0]
//   ifid_valid   IF/ID holds a real instruction (0 = bubble)
//   fetch_cnt    valid instructions loaded into IF/ID
//   bubble_cnt   cycles IF/ID was loaded with a redirect bubble
//   stall_cnt    cycles with stall=1 and redirect=0
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc4,
  output logic [31:0] ifid_instr,
  output logic [6:0]  ifid_opcode,
  output logic        ifid_valid,
  output logic [31:0] fetch_cnt,
  output logic [31:0] bubble_cnt,
  output logic [31:0] stall_cnt
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] redirect_target;

  // Masking keeps every bit of redirect_pc in use while forcing word alignment.
  assign redirect_target = redirect_pc & ~32'h0000_0003;

  // Next-state selection. Priority is redirect > stall > advance. Reset is
  // applied in the register process so that it overrides all three.
  always_comb begin
    pc_d         = pc_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    fetch_cnt_d  = fetch_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    stall_cnt_d  = stall_cnt_q;

    if (redirect) begin
      pc_d         = redirect_target;
      ifid_pc_d    = 32'h0;
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end else if (stall) begin
      // Everything holds. A held bubble stays a bubble.
      stall_cnt_d  = stall_cnt_q + 32'd1;
    end else begin
      ifid_pc_d    = pc_q;
      ifid_instr_d = imem_rdata;
      ifid_valid_d = 1'b1;
      pc_d         = pc_q + 32'd4;
      fetch_cnt_d  = fetch_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      ifid_pc_q    <= 32'h0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
      fetch_cnt_q  <= 32'h0;
      bubble_cnt_q <= 32'h0;
      stall_cnt_q  <= 32'h0;
    end else begin
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign imem_addr   = pc_q;
  assign ifid_pc     = ifid_pc_q;
  assign ifid_pc4    = ifid_pc_q + 32'd4;
  assign ifid_instr  = ifid_instr_q;
  assign ifid_opcode = ifid_instr_q[6:0];
  assign ifid_valid  = ifid_valid_q;
  assign fetch_cnt   = fetch_cnt_q;
  assign bubble_cnt  = bubble_cnt_q;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//
// Testbench for fetch_stage. The driver applies one set of inputs per cycle
// on the falling edge. It steps an architectural model of the stage, then
// queues the outputs expected after the next rising edge. A separate monitor
// samples the DUT just after every rising edge and compares it against the
// queued expectation. The instruction memory is a pure function of the
// address, so the model can work out every fetched word on its own.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc4;
  logic [31:0] ifid_instr;
  logic [6:0]  ifid_opcode;
  logic        ifid_valid;
  logic [31:0] fetch_cnt;
  logic [31:0] bubble_cnt;
  logic [31:0] stall_cnt;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic        valid;
    logic [31:0] fetches;
    logic [31:0] bubbles;
    logic [31:0] stalls;
    string       tag;
  } expect_t;

  expect_t expectQ[$];

  int  checkCount = 0;
  int  failCount  = 0;
  bit  driveDone  = 0;

  // Architectural model state
  logic [31:0] mPc, mIfPc, mInstr, mFetch, mBubble, mStall;
  logic        mValid;

  fetch_stage #(
    .RESET_PC (RESET_PC),
    .NOP_INSTR(NOP_INSTR)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .ifid_pc    (ifid_pc),
    .ifid_pc4   (ifid_pc4),
    .ifid_instr (ifid_instr),
    .ifid_opcode(ifid_opcode),
    .ifid_valid (ifid_valid),
    .fetch_cnt  (fetch_cnt),
    .bubble_cnt (bubble_cnt),
    .stall_cnt  (stall_cnt)
  );

  // The instruction memory holds 0x1000_0000 + word index at every word address.
  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return 32'h1000_0000 + (addr >> 2);
  endfunction

  assign imem_rdata = memWord(imem_addr);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // This task drives one cycle of inputs. It also advances the model for the
  // coming edge and queues the outputs expected after that edge.
  task automatic applyStimulus(input bit rst, input bit stl, input bit rdr,
                               input logic [31:0] rpc, input string tag);
    expect_t e;
    @(negedge clk);
    reset       = rst;
    stall       = stl;
    redirect    = rdr;
    redirect_pc = rpc;
    if (rst) begin
      mPc = RESET_PC; mIfPc = 0; mInstr = NOP_INSTR; mValid = 0;
      mFetch = 0; mBubble = 0; mStall = 0;
    end else if (rdr) begin
      mPc = {rpc[31:2], 2'b00};
      mIfPc = 0; mInstr = NOP_INSTR; mValid = 0;
      mBubble = mBubble + 1;
    end else if (stl) begin
      mStall = mStall + 1;
    end else begin
      mIfPc = mPc; mInstr = memWord(mPc); mValid = 1;
      mPc = mPc + 4;
      mFetch = mFetch + 1;
    end
    e.addr    = mPc;
    e.pc      = mIfPc;
    e.pc4     = mIfPc + 4;
    e.instr   = mInstr;
    e.opcode  = mInstr[6:0];
    e.valid   = mValid;
    e.fetches = mFetch;
    e.bubbles = mBubble;
    e.stalls  = mStall;
    e.tag     = tag;
    expectQ.push_back(e);
  endtask

  task automatic compareField(input string tag, input string name,
                              input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s.%s actual=%h expected=%h at %0t", tag, name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input expect_t e);
    compareField(e.tag, "imem_addr",   imem_addr,          e.addr);
    compareField(e.tag, "ifid_pc",     ifid_pc,            e.pc);
    compareField(e.tag, "ifid_pc4",    ifid_pc4,           e.pc4);
    compareField(e.tag, "ifid_instr",  ifid_instr,         e.instr);
    compareField(e.tag, "ifid_opcode", {25'h0, ifid_opcode}, {25'h0, e.opcode});
    compareField(e.tag, "ifid_valid",  {31'h0, ifid_valid},  {31'h0, e.valid});
    compareField(e.tag, "fetch_cnt",   fetch_cnt,          e.fetches);
    compareField(e.tag, "bubble_cnt",  bubble_cnt,         e.bubbles);
    compareField(e.tag, "stall_cnt",   stall_cnt,          e.stalls);
  endtask

  // The monitor compares every queued expectation against the DUT just after
  // a rising edge. The number of cycles it waits is bounded.
  initial begin
    int cycles = 0;
    expect_t e;
    while (!driveDone || expectQ.size() > 0) begin
      @(posedge clk);
      #1;
      cycles++;
      if (expectQ.size() > 0) begin
        e = expectQ.pop_front();
        checkOutput(e);
      end
      if (cycles > 20000) begin
        checkCount++;
        failCount++;
        $display("[TB] FAIL monitor_timeout actual=%0d cycles expected=drain before 20000", cycles);
        break;
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

  // Driver: directed scenarios first, then a randomized run.
  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    mPc = 0; mIfPc = 0; mInstr = NOP_INSTR; mValid = 0;
    mFetch = 0; mBubble = 0; mStall = 0;

    applyStimulus(1, 0, 0, 0, "reset");
    applyStimulus(1, 0, 0, 0, "reset");
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, "run");
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, "stall3");
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 0, "run");
    // redirect to 0x103 lands on 0x100
    applyStimulus(1, 0, 0, 0, "reset");
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, "run");
    applyStimulus(0, 0, 1, 32'h0000_0103, "redir");
    applyStimulus(0, 0, 0, 0, "after_redir");
    applyStimulus(0, 1, 0, 0, "stall_mid");
    // redirect and stall together behave as a redirect
    applyStimulus(0, 1, 1, 32'h0000_0200, "redir_stall");
    applyStimulus(0, 1, 0, 0, "stall_bubble");
    applyStimulus(0, 0, 0, 0, "run");
    // PC wrap
    applyStimulus(0, 0, 1, 32'hFFFF_FFFE, "redir_top");
    applyStimulus(0, 0, 0, 0, "wrap");
    applyStimulus(0, 0, 0, 0, "wrap");
    // reset during a stall at pc 0x40
    applyStimulus(0, 0, 1, 32'h0000_0040, "redir40");
    applyStimulus(0, 1, 0, 0, "stall40");
    applyStimulus(1, 1, 0, 0, "reset_in_stall");
    applyStimulus(0, 0, 0, 0, "run");
    // reset during a redirect
    applyStimulus(1, 0, 1, 32'h0000_0800, "reset_in_redir");
    applyStimulus(0, 0, 0, 0, "run");

    for (int i = 0; i < 400; i++) begin
      automatic int r = $urandom_range(0, 99);
      automatic bit rst = (r < 2);
      automatic bit rdr = ($urandom_range(0, 99) < 12);
      automatic bit stl = ($urandom_range(0, 99) < 25);
      automatic logic [31:0] rpc = $urandom;
      applyStimulus(rst, stl, rdr, rpc, "random");
    end
    driveDone = 1;
  end

endmodule
